// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the execute-stage ALU and the
//                sequencers that time-share it: datapath width, ALU
//                operation encodings and the multiply/divide sequencer
//                state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Datapath width of the shared ripple ALU.
  localparam int unsigned ALU_WIDTH = 32;

  // ALU operation select encodings.
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  // Multiply/divide sequencer state encoding.
  typedef logic [1:0] seq_state_t;
  localparam seq_state_t ST_IDLE = 2'd0;
  localparam seq_state_t ST_MUL  = 2'd1;
  localparam seq_state_t ST_DIV  = 2'd2;
  localparam seq_state_t ST_FIN  = 2'd3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_carry_recover.sv
`default_nettype none
// ============================================================================
//  Module      : alu_carry_recover
//  Description : Recovers the carry-out (add) or borrow (subtract) of a
//                two's-complement adder from the operand and result MSBs.
//                The shared ALU has no carry-out pin, so any sequencer that
//                needs the 33rd bit rebuilds it here.
//  Ports       : i_a31   - MSB of ALU operand a
//                i_b31   - MSB of ALU operand b (before bnegate inversion)
//                i_r31   - MSB of ALU result
//                i_sub   - 1: operation was a - b, 0: a + b
//                o_carry - carry-out for add, borrow for subtract
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_carry_recover (
  input  logic i_a31,
  input  logic i_b31,
  input  logic i_r31,
  input  logic i_sub,
  output logic o_carry
);

  logic w_carry_add;
  logic w_borrow_sub;

  // Add: carry if both MSBs set, or exactly one set and the sum MSB cleared.
  assign w_carry_add  = (i_a31 & i_b31) | ((i_a31 | i_b31) & ~i_r31);
  // Subtract: borrow if a < b judged from MSBs, or MSBs equal and the
  // difference wrapped negative.
  assign w_borrow_sub = (~i_a31 & i_b31) | (~(i_a31 ^ i_b31) & i_r31);

  assign o_carry = i_sub ? w_borrow_sub : w_carry_add;

endmodule : alu_carry_recover
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq
//  Description : Multi-cycle unsigned multiply / restoring divide sequencer.
//                Performs one add or subtract per clock on the shared
//                execute-stage ALU, owning its operands and control lines
//                while busy. A start in cycle 0 gives done in cycle WIDTH+1;
//                divide by zero finishes in cycle 1.
//  Ports       : clk             - clock, rising edge
//                rst_n           - asynchronous active-low reset
//                i_start         - begin operation (sampled in IDLE only)
//                i_op_div        - 0 multiply, 1 divide
//                i_src_a         - multiplicand / dividend
//                i_src_b         - multiplier / divisor
//                o_busy          - operation in progress (MUL, DIV, FIN)
//                o_done          - one-cycle completion pulse
//                o_div_zero      - divisor was zero (valid with done)
//                o_hi / o_lo     - product high/low, or remainder/quotient
//                o_alu_a/_b      - ALU operands
//                o_alu_ainvert   - ALU ainvert control
//                o_alu_bnegate   - ALU bnegate control
//                o_alu_operation - ALU operation select
//                i_alu_result    - ALU combinational result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_op_div,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic             o_alu_ainvert,
  output logic             o_alu_bnegate,
  output logic [1:0]       o_alu_operation,
  input  logic [WIDTH-1:0] i_alu_result
);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  // Multiplicand in MUL, divisor in DIV; never needed at the same time.
  logic [WIDTH-1:0] r_opb;
  logic             r_div_zero;

  logic [WIDTH-1:0] w_rs;
  logic             w_m;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic             w_alu_bnegate;
  logic [1:0]       w_alu_operation;
  logic             w_sub;
  logic             w_carry;
  logic             w_last_step;

  // Partial remainder shifted left by one with the next dividend bit;
  // w_m is the bit shifted out, i.e. bit WIDTH of the 33-bit remainder.
  assign w_rs = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_m  = r_hi[WIDTH-1];

  assign w_sub       = (r_state == ST_DIV);
  assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

  // ALU drive: idle values everywhere except the two stepping states.
  always_comb begin
    w_alu_a         = '0;
    w_alu_b         = '0;
    w_alu_bnegate   = 1'b0;
    w_alu_operation = ALU_AND;
    case (r_state)
      ST_MUL: begin
        w_alu_a         = r_hi;
        w_alu_b         = r_lo[0] ? r_opb : '0;
        w_alu_operation = ALU_ADD;
      end
      ST_DIV: begin
        w_alu_a         = w_rs;
        w_alu_b         = r_opb;
        w_alu_bnegate   = 1'b1;
        w_alu_operation = ALU_ADD;
      end
      default: ;
    endcase
  end

  alu_carry_recover u_carry (
    .i_a31   (w_alu_a[WIDTH-1]),
    .i_b31   (w_alu_b[WIDTH-1]),
    .i_r31   (i_alu_result[WIDTH-1]),
    .i_sub   (w_sub),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opb      <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            if (!i_op_div) begin
              r_opb   <= i_src_a;
              r_lo    <= i_src_b;
              r_hi    <= '0;
              r_state <= ST_MUL;
            end else if (i_src_b != '0) begin
              r_opb   <= i_src_b;
              r_lo    <= i_src_a;
              r_hi    <= '0;
              r_state <= ST_DIV;
            end else begin
              r_hi       <= i_src_a;
              r_lo       <= '1;
              r_div_zero <= 1'b1;
              r_state    <= ST_FIN;
            end
          end
        end

        ST_MUL: begin
          // Shift the 65-bit {carry, sum, lo} right by one.
          {r_hi, r_lo} <= {w_carry, i_alu_result, r_lo[WIDTH-1:1]};
          r_cnt        <= r_cnt + 1'b1;
          if (w_last_step) begin
            r_state <= ST_FIN;
          end
        end

        ST_DIV: begin
          // Remainder >= divisor when the shifted-out bit is set or the
          // subtraction did not borrow; then keep the difference.
          if (w_m | ~w_carry) begin
            r_hi <= i_alu_result;
            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_hi <= w_rs;
            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (w_last_step) begin
            r_state <= ST_FIN;
          end
        end

        ST_FIN: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = (r_state == ST_FIN);
  assign o_div_zero      = r_div_zero;
  assign o_hi            = r_hi;
  assign o_lo            = r_lo;
  assign o_alu_a         = w_alu_a;
  assign o_alu_b         = w_alu_b;
  assign o_alu_ainvert   = 1'b0;
  assign o_alu_bnegate   = w_alu_bnegate;
  assign o_alu_operation = w_alu_operation;

endmodule : alu_muldiv_seq
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv_seq
//  Description : Self-checking bench for alu_muldiv_seq. Provides a
//                behavioural model of the shared ALU, issues directed and
//                random multiply/divide operations, and compares each done
//                against expected results computed with native 64-bit
//                arithmetic held in a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic          i_op_div;
  logic [W-1:0]  i_src_a;
  logic [W-1:0]  i_src_b;
  logic          o_busy;
  logic          o_done;
  logic          o_div_zero;
  logic [W-1:0]  o_hi;
  logic [W-1:0]  o_lo;
  logic [W-1:0]  o_alu_a;
  logic [W-1:0]  o_alu_b;
  logic          o_alu_ainvert;
  logic          o_alu_bnegate;
  logic [1:0]    o_alu_operation;
  logic [W-1:0]  alu_res;

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_op_div        (i_op_div),
    .i_src_a         (i_src_a),
    .i_src_b         (i_src_b),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_div_zero      (o_div_zero),
    .o_hi            (o_hi),
    .o_lo            (o_lo),
    .o_alu_a         (o_alu_a),
    .o_alu_b         (o_alu_b),
    .o_alu_ainvert   (o_alu_ainvert),
    .o_alu_bnegate   (o_alu_bnegate),
    .o_alu_operation (o_alu_operation),
    .i_alu_result    (alu_res)
  );

  // Behavioural model of the shared ripple ALU.
  logic [W-1:0] alu_ea;
  logic [W-1:0] alu_eb;
  logic [W-1:0] alu_sum;
  always_comb begin
    alu_ea  = o_alu_ainvert ? ~o_alu_a : o_alu_a;
    alu_eb  = o_alu_bnegate ? ~o_alu_b : o_alu_b;
    alu_sum = alu_ea + alu_eb + {{(W-1){1'b0}}, o_alu_bnegate};
    case (o_alu_operation)
      2'b00:   alu_res = alu_ea & alu_eb;
      2'b01:   alu_res = alu_ea | alu_eb;
      2'b10:   alu_res = alu_sum;
      default: alu_res = {{(W-1){1'b0}}, alu_sum[W-1]};
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference results from plain arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic div, input int start_cyc);
    exp_t e;
    logic [63:0] p;
    if (!div) begin
      p    = {32'd0, a} * {32'd0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dz = 1'b0;
      e.due = start_cyc + W + 1;
    end else if (b == 0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
      e.due = start_cyc + 1;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
      e.dz = 1'b0;
      e.due = start_cyc + W + 1;
    end
    return e;
  endfunction

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hi", {32'd0, o_hi}, {32'd0, e.hi});
        chk("lo", {32'd0, o_lo}, {32'd0, e.lo});
        chk("div_zero", {63'd0, o_div_zero}, {63'd0, e.dz});
        chk("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Accepted start: drive for one cycle and record the expectation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic div);
    @(negedge clk);
    i_start  = 1'b1;
    i_op_div = div;
    i_src_a  = a;
    i_src_b  = b;
    exp_q.push_back(model(a, b, div, cyc));
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int bad;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rd;
    logic [W-1:0] save_hi;
    logic [W-1:0] save_lo;

    rst_n    = 1'b0;
    i_start  = 1'b0;
    i_op_div = 1'b0;
    i_src_a  = '0;
    i_src_b  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_hi_lo", {o_hi, o_lo}, 64'd0);
    chk("rst_alu_ab", {o_alu_a, o_alu_b}, 64'd0);
    chk("rst_alu_ctl", {60'd0, o_alu_ainvert, o_alu_bnegate, o_alu_operation}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 7 x 6 with busy profile over cycles 1..33.
    issue(32'd7, 32'd6, 1'b0);
    bad = 0;
    for (int i = 1; i <= 33; i++) begin
      if (o_busy !== 1'b1) bad++;
      if (i < 33) @(negedge clk);
    end
    chk("busy_cycles_1_33", 64'(bad), 64'd0);
    @(negedge clk);
    chk("busy_after_done", {63'd0, o_busy}, 64'd0);
    chk("alu_idle_after", {o_alu_a, o_alu_b}, 64'd0);
    save_hi = o_hi;
    save_lo = o_lo;
    repeat (3) @(negedge clk);
    chk("hold_result", {o_hi, o_lo}, {save_hi, save_lo});

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    issue(32'd100, 32'd7, 1'b1);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_idle();
    issue(32'h8000_0000, 32'h8000_0001, 1'b1);
    wait_idle();

    // Divide by zero, then div_zero must drop on the next accepted start.
    issue(32'h1234_5678, 32'd0, 1'b1);
    wait_idle();
    chk("dz_held", {63'd0, o_div_zero}, 64'd1);
    issue(32'd9, 32'd3, 1'b1);
    chk("dz_cleared", {63'd0, o_div_zero}, 64'd0);
    wait_idle();

    // Start re-pulsed at cycles 5 and 33 of a multiply must be ignored.
    issue(32'h0001_2345, 32'h0000_BEEF, 1'b0);
    repeat (4) @(negedge clk);
    i_start = 1'b1; i_op_div = 1'b1; i_src_a = 32'hDEAD_BEEF; i_src_b = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (27) @(negedge clk);
    i_start = 1'b1; i_op_div = 1'b0; i_src_a = 32'd5; i_src_b = 32'd5;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_accept_at_fin", {63'd0, o_busy}, 64'd0);

    // Asynchronous reset in cycle 10 of a divide.
    issue(32'hCAFE_F00D, 32'd13, 1'b1);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_busy_done", {62'd0, o_busy, o_done}, 64'd0);
    chk("arst_hi_lo", {o_hi, o_lo}, 64'd0);
    chk("arst_alu", {o_alu_a, o_alu_b}, 64'd0);
    chk("arst_alu_ctl", {60'd0, o_alu_ainvert, o_alu_bnegate, o_alu_operation}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'hCAFE_F00D, 32'd13, 1'b1);
    wait_idle();

    // Random traffic.
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom;
      rd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: ra = W'($urandom_range(0, 255));
        default: ;
      endcase
      issue(ra, rb, rd);
      wait_idle();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_muldiv_seq
`default_nettype wire
